// File: rtl/alarm_scheduler.sv
// Shares one siren among five latched alarm sources, served in fixed priority with timed bursts.
// Optional fire preemption is enabled by defining ALARM_PREEMPT_EN.
module alarm_scheduler #(
   parameter int BURST_CYCLES = 8,
   parameter int GAP_CYCLES   = 4,
   parameter int BURSTS       = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] req,
   input  logic       ack,
   output logic       siren,
   output logic [2:0] active_src,
   output logic [4:0] pending,
   output logic       busy,
   output logic       done
);
   localparam int MAX_CYCLES = (BURST_CYCLES > GAP_CYCLES) ? BURST_CYCLES : GAP_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam int BW = $clog2(BURSTS + 1);
   localparam logic [CW-1:0] BURST_LAST = CW'(BURST_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
   localparam logic [BW-1:0] BURST_MAX  = BW'(BURSTS);
   localparam logic [2:0]    NONE       = 3'd7;

   typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

   state_t        state;
   logic [4:0]    req_q;
   logic [4:0]    rise;
   logic [4:0]    clr;
   logic [CW-1:0] cnt;
   logic [BW-1:0] burst;
   logic [2:0]    next_src;
   logic          serving;
   logic          preempt;
   logic          finish;

   always_comb begin
      rise    = req & ~req_q;
      serving = (state != IDLE);
`ifdef ALARM_PREEMPT_EN
      preempt = serving && (active_src != 3'd0) && pending[0];
`else
      preempt = 1'b0;
`endif
      // Preemption outranks completion: the preempted source must stay pending.
      finish  = (state == ON) && (cnt == BURST_LAST) && (burst == BURST_MAX) && !preempt;
      clr     = '0;
      if (serving && (ack || finish))
         clr = 5'b00001 << active_src;
      next_src = NONE;
      for (int unsigned i = 5; i > 0; i--)
         if (pending[i-1])
            next_src = 3'(i - 1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         req_q      <= '0;
         pending    <= '0;
         cnt        <= '0;
         burst      <= '0;
         active_src <= NONE;
         siren      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         req_q   <= req;
         // A new rising edge wins over a same-cycle clear.
         pending <= (pending & ~clr) | rise;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (next_src != NONE) begin
                  state      <= ON;
                  active_src <= next_src;
                  cnt        <= '0;
                  burst      <= BW'(1);
                  siren      <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            default: begin
               if (ack || preempt || finish) begin
                  state      <= IDLE;
                  active_src <= NONE;
                  siren      <= 1'b0;
                  busy       <= 1'b0;
                  done       <= finish && !ack;
               end else if (state == ON) begin
                  if (cnt == BURST_LAST) begin
                     state <= OFF;
                     cnt   <= '0;
                     siren <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  if (cnt == GAP_LAST) begin
                     state <= ON;
                     cnt   <= '0;
                     burst <= burst + 1'b1;
                     siren <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alarm_scheduler.sv
// Randomized bench for alarm_scheduler against an elapsed-time service model.
module tb_alarm_scheduler;
   localparam int BURST_CYCLES = 8;
   localparam int GAP_CYCLES   = 4;
   localparam int BURSTS       = 3;
   localparam int TOTAL        = BURSTS * BURST_CYCLES + (BURSTS - 1) * GAP_CYCLES;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] req;
   logic       ack;
   logic       siren;
   logic [2:0] active_src;
   logic [4:0] pending;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   // Model: which source is in service and how many cycles it has run.
   logic [4:0] m_reqq;
   logic [4:0] m_pend;
   int         m_src;
   int         m_el;
   logic       m_done;

   alarm_scheduler #(
      .BURST_CYCLES(BURST_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES),
      .BURSTS      (BURSTS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .ack       (ack),
      .siren     (siren),
      .active_src(active_src),
      .pending   (pending),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   task model_reset();
      m_reqq = '0;
      m_pend = '0;
      m_src  = -1;
      m_el   = 0;
      m_done = 1'b0;
   endtask

   task model_step(input logic [4:0] r, input logic a);
      logic [4:0] rise;
      logic [4:0] clear;
      rise   = r & ~m_reqq;
      clear  = '0;
      m_done = 1'b0;
      if (m_src >= 0) begin
         if (a) begin
            clear[m_src] = 1'b1;
            m_src = -1;
         end
`ifdef ALARM_PREEMPT_EN
         else if (m_src != 0 && m_pend[0]) begin
            m_src = -1;
         end
`endif
         else if (m_el == TOTAL - 1) begin
            clear[m_src] = 1'b1;
            m_done = 1'b1;
            m_src = -1;
         end else begin
            m_el++;
         end
      end else if (m_pend != '0) begin
         for (int i = 4; i >= 0; i--)
            if (m_pend[i]) m_src = i;
         m_el = 0;
      end
      m_pend = (m_pend & ~clear) | rise;
      m_reqq = r;
   endtask

   task check_outputs(input string phase);
      logic e_busy;
      logic e_siren;
      logic [7:0] e_src;
      e_busy  = (m_src >= 0);
      e_siren = e_busy && ((m_el % (BURST_CYCLES + GAP_CYCLES)) < BURST_CYCLES);
      e_src   = e_busy ? 8'(m_src) : 8'd7;
      check({phase, ".siren"},  {7'd0, siren}, {7'd0, e_siren});
      check({phase, ".busy"},   {7'd0, busy},  {7'd0, e_busy});
      check({phase, ".done"},   {7'd0, done},  {7'd0, m_done});
      check({phase, ".src"},    {5'd0, active_src}, e_src);
      check({phase, ".pending"}, {3'd0, pending}, {3'd0, m_pend});
   endtask

   initial begin
      reset = 1'b0;
      req   = '0;
      ack   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      reset = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk);
         model_step(req, ack);
         #1;
         check_outputs("run");
         ack = 1'b0;
         if (cyc == 1500 || cyc == 2900) begin
            req[3] = 1'b1;
            #2 reset = 1'b0;
            #1;
            model_reset();
            check_outputs("async_rst");
            @(posedge clk);
            #1;
            check_outputs("in_rst");
            reset = 1'b1;
         end else begin
            for (int i = 0; i < 5; i++)
               if ($urandom_range(0, 59) == 0) req[i] = ~req[i];
            if ($urandom_range(0, 299) == 0) req = 5'($urandom);
            if ($urandom_range(0, 89) == 0) ack = 1'b1;
            if (m_src >= 0 && m_el == TOTAL - 1 && $urandom_range(0, 2) == 0) ack = 1'b1;
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
